// File: rtl/pipe_mem_stage_pkg.sv
// Shared types and constants for the MEM stage of the 5-stage pipeline.
package pipe_mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
  } memwb_t;

endpackage

// File: rtl/pipe_mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read and
// alignment check on the byte address.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              write_allow,
  input  logic [AW+1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0]     idx;
  logic              aligned;
  logic              we;

  assign idx        = addr[AW+1:2];
  assign aligned    = (addr[1:0] == 2'b00);
  assign misaligned = (mem_read | mem_write) & ~aligned;

  // A reset coinciding with the edge must not let a store through.
  assign we = mem_write & aligned & write_allow & ~reset;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = (mem_read && aligned) ? mem_q[idx] : '0;

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: store-data forward mux, data memory access and MEM/WB register
// with sticky misalignment flag.
module pipe_mem_stage
  import pipe_mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic              exmem_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic [DATA_W-1:0] exmem_write_data,
  input  logic [4:0]        exmem_write_reg,
  input  logic              forward_m,
  input  logic              memwb_stall,
  input  logic              memwb_flush,
  output logic              memwb_reg_write,
  output logic              memwb_mem_to_reg,
  output logic [4:0]        memwb_write_reg,
  output logic [DATA_W-1:0] memwb_read_data,
  output logic [DATA_W-1:0] memwb_alu_result,
  output logic [DATA_W-1:0] memwb_result,
  output logic              align_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  memwb_t            memwb_q, memwb_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              misaligned;

  assign memwb_result = memwb_q.mem_to_reg ? memwb_q.read_data : memwb_q.alu_result;

  // lw-to-sw forward: the WB value replaces the stale rt captured in EX/MEM.
  assign store_data = forward_m ? memwb_result : exmem_write_data;

  data_memory #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W),
    .AW         (AW)
  ) u_dmem (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (exmem_mem_read),
    .mem_write  (exmem_mem_write),
    .write_allow(~memwb_stall & ~memwb_flush),
    .addr       (exmem_alu_result[AW+1:0]),
    .wdata      (store_data),
    .rdata      (mem_rdata),
    .misaligned (misaligned)
  );

  always_comb begin
    memwb_d = memwb_q;
    fault_d = fault_q | misaligned;
    if (memwb_flush) begin
      memwb_d = '0;
    end else if (!memwb_stall) begin
      memwb_d.reg_write  = exmem_reg_write;
      memwb_d.mem_to_reg = exmem_mem_to_reg;
      memwb_d.write_reg  = exmem_write_reg;
      memwb_d.read_data  = mem_rdata;
      memwb_d.alu_result = exmem_alu_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_q <= '0;
      fault_q <= 1'b0;
    end else begin
      memwb_q <= memwb_d;
      fault_q <= fault_d;
    end
  end

  assign memwb_reg_write  = memwb_q.reg_write;
  assign memwb_mem_to_reg = memwb_q.mem_to_reg;
  assign memwb_write_reg  = memwb_q.write_reg;
  assign memwb_read_data  = memwb_q.read_data;
  assign memwb_alu_result = memwb_q.alu_result;
  assign align_fault      = fault_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: directed vector table, reset corner cases and
// randomized traffic against a word-array reference model.
module tb_pipe_mem_stage;

  logic        clk, reset;
  logic        rd, wr, mtr, rw, fwd, stall, flush;
  logic [31:0] alu, wdata;
  logic [4:0]  wreg;
  logic        o_rw, o_mtr, o_fault;
  logic [4:0]  o_wreg;
  logic [31:0] o_rd, o_alu, o_res;

  int checks = 0;
  int failures = 0;

  pipe_mem_stage #(.DEPTH_WORDS(256), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .exmem_mem_read(rd), .exmem_mem_write(wr), .exmem_mem_to_reg(mtr),
    .exmem_reg_write(rw), .exmem_alu_result(alu), .exmem_write_data(wdata),
    .exmem_write_reg(wreg), .forward_m(fwd), .memwb_stall(stall),
    .memwb_flush(flush), .memwb_reg_write(o_rw), .memwb_mem_to_reg(o_mtr),
    .memwb_write_reg(o_wreg), .memwb_read_data(o_rd),
    .memwb_alu_result(o_alu), .memwb_result(o_res), .align_fault(o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, mtr, rw;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
    logic        fwd, stall, flush;
    logic        e_rw, e_mtr;
    logic [4:0]  e_wreg;
    logic [31:0] e_rd, e_alu, e_res;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  logic [31:0] mem_m [256];
  logic        m_rw, m_mtr, m_fault;
  logic [4:0]  m_wreg;
  logic [31:0] m_rd, m_alu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rw, input logic e_mtr,
                         input logic [4:0] e_wreg, input logic [31:0] e_rd,
                         input logic [31:0] e_alu, input logic [31:0] e_res,
                         input logic e_fault);
    chk({tag, ".reg_write"},  {31'd0, o_rw},    {31'd0, e_rw});
    chk({tag, ".mem_to_reg"}, {31'd0, o_mtr},   {31'd0, e_mtr});
    chk({tag, ".write_reg"},  {27'd0, o_wreg},  {27'd0, e_wreg});
    chk({tag, ".read_data"},  o_rd,             e_rd);
    chk({tag, ".alu_result"}, o_alu,            e_alu);
    chk({tag, ".result"},     o_res,            e_res);
    chk({tag, ".align_fault"}, {31'd0, o_fault}, {31'd0, e_fault});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic m2r, input logic rgw,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr_reg,
                       input logic f, input logic s, input logic fl);
    rd = r; wr = w; mtr = m2r; rw = rgw; alu = a; wdata = d; wreg = wr_reg;
    fwd = f; stall = s; flush = fl;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic m2r, input logic rgw,
                              input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr_reg,
                              input logic f, input logic s, input logic fl,
                              input logic e_rw, input logic e_mtr, input logic [4:0] e_wreg,
                              input logic [31:0] e_rd, input logic [31:0] e_alu,
                              input logic [31:0] e_res, input logic e_fault);
    vec_t v;
    v.rd = r; v.wr = w; v.mtr = m2r; v.rw = rgw; v.addr = a; v.wdata = d;
    v.wreg = wr_reg; v.fwd = f; v.stall = s; v.flush = fl;
    v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_wreg = e_wreg; v.e_rd = e_rd;
    v.e_alu = e_alu; v.e_res = e_res; v.e_fault = e_fault;
    return v;
  endfunction

  function automatic void model_reset();
    m_rw = 0; m_mtr = 0; m_wreg = 0; m_rd = 0; m_alu = 0; m_fault = 0;
  endfunction

  // Predict from the current inputs, advance one edge, compare.
  task automatic model_step(input string tag);
    logic        al;
    logic [7:0]  ix;
    logic [31:0] rdv, sd, wbv;
    al  = (alu[1:0] == 2'b00);
    ix  = alu[9:2];
    wbv = m_mtr ? m_rd : m_alu;
    rdv = (rd && al) ? mem_m[ix] : 32'd0;
    sd  = fwd ? wbv : wdata;
    if (wr && al && !stall && !flush) mem_m[ix] = sd;
    if ((rd || wr) && !al) m_fault = 1'b1;
    if (flush) begin
      m_rw = 0; m_mtr = 0; m_wreg = 0; m_rd = 0; m_alu = 0;
    end else if (!stall) begin
      m_rw = rw; m_mtr = mtr; m_wreg = wreg; m_rd = rdv; m_alu = alu;
    end
    step();
    chk_all(tag, m_rw, m_mtr, m_wreg, m_rd, m_alu, m_mtr ? m_rd : m_alu, m_fault);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    chk_all("reset_init", 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;

    //          rd wr m2r rw addr          wdata         wreg f  s  fl | rw mtr wreg rd           alu           res           flt
    vecs.push_back(mk(0,1,0,0, 32'h10,       32'hDEADBEEF, 0, 0,0,0, 0,0,0, 0,            32'h10,       32'h10,       0));
    vecs.push_back(mk(1,0,1,1, 32'h10,       0,            2, 0,0,0, 1,1,2, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 0));
    vecs.push_back(mk(0,1,0,0, 32'h20,       32'h12345678, 0, 0,0,0, 0,0,0, 0,            32'h20,       32'h20,       0));
    vecs.push_back(mk(1,0,1,1, 32'h20,       0,            1, 0,0,0, 1,1,1, 32'h12345678, 32'h20,       32'h12345678, 0));
    vecs.push_back(mk(0,1,0,0, 32'h24,       32'hBAD,      0, 1,0,0, 0,0,0, 0,            32'h24,       32'h24,       0));
    vecs.push_back(mk(1,0,1,1, 32'h24,       0,            3, 0,0,0, 1,1,3, 32'h12345678, 32'h24,       32'h12345678, 0));
    vecs.push_back(mk(1,0,1,1, 32'h20,       0,            1, 0,0,0, 1,1,1, 32'h12345678, 32'h20,       32'h12345678, 0));
    vecs.push_back(mk(0,1,0,0, 32'h24,       32'hBAD,      0, 0,0,0, 0,0,0, 0,            32'h24,       32'h24,       0));
    vecs.push_back(mk(1,0,1,1, 32'h24,       0,            3, 0,0,0, 1,1,3, 32'hBAD,      32'h24,       32'hBAD,      0));
    vecs.push_back(mk(0,1,0,0, 32'h13,       32'h77,       0, 0,0,0, 0,0,0, 0,            32'h13,       32'h13,       1));
    vecs.push_back(mk(1,0,1,1, 32'h10,       0,            2, 0,0,0, 1,1,2, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 1));
    vecs.push_back(mk(1,0,1,1, 32'h11,       0,            4, 0,0,0, 1,1,4, 0,            32'h11,       0,            1));
    vecs.push_back(mk(1,0,1,1, 32'h10,       0,            2, 0,0,0, 1,1,2, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 1));
    vecs.push_back(mk(0,1,0,0, 32'h10,       32'h99,       0, 0,1,0, 1,1,2, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 1));
    vecs.push_back(mk(1,0,1,1, 32'h10,       0,            5, 0,0,0, 1,1,5, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 1));
    vecs.push_back(mk(0,1,0,0, 32'h10,       32'h99,       0, 0,1,1, 0,0,0, 0,            0,            0,            1));
    vecs.push_back(mk(1,0,1,1, 32'h10,       0,            5, 0,0,0, 1,1,5, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 1));
    vecs.push_back(mk(0,1,0,0, 32'h400,      32'h55,       0, 0,0,0, 0,0,0, 0,            32'h400,      32'h400,      1));
    vecs.push_back(mk(1,0,1,1, 32'h0,        0,            6, 0,0,0, 1,1,6, 32'h55,       32'h0,        32'h55,       1));
    vecs.push_back(mk(0,0,0,1, 32'hCAFE0001, 0,            7, 0,0,0, 1,0,7, 0,            32'hCAFE0001, 32'hCAFE0001, 1));
    vecs.push_back(mk(0,1,0,0, 32'h30,       32'h0,        0, 1,0,0, 0,0,0, 0,            32'h30,       32'h30,       1));
    vecs.push_back(mk(1,0,1,1, 32'h30,       0,            8, 0,0,0, 1,1,8, 32'hCAFE0001, 32'h30,       32'hCAFE0001, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].mtr, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
            vecs[i].wreg, vecs[i].fwd, vecs[i].stall, vecs[i].flush);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_mtr, vecs[i].e_wreg,
              vecs[i].e_rd, vecs[i].e_alu, vecs[i].e_res, vecs[i].e_fault);
    end

    // mid-cycle async reset clears outputs immediately; a store held under reset is blocked
    drive(0, 1, 0, 0, 32'h10, 32'hAAAA, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk_all("reset_async", 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    chk_all("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 32'h10, 0, 2, 0, 0, 0);
    step();
    chk_all("reset_blocks_write", 1, 1, 2, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 0);

    // randomized traffic against the reference model
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 0, i * 4, $urandom, 0, 0, 0, 0);
      model_step("prefill");
    end
    for (int n = 0; n < 900; n++) begin
      logic r, w;
      logic [31:0] a;
      if (n % 300 == 299) begin
        #3;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        chk_all("rnd_reset", 0, 0, 0, 0, 0, 0, 0);
      end
      case ($urandom_range(0, 9))
        0, 1, 2: begin r = 1; w = 0; end
        3, 4, 5: begin r = 0; w = 1; end
        6:       begin r = 1; w = 1; end
        default: begin r = 0; w = 0; end
      endcase
      a = $urandom;
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(r, w, r, $urandom_range(0, 1) == 1, a, $urandom, 5'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0);
      model_step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the WB stage.
- Consumes the lw-to-sw forward select (forward_m) generated by the memory-forwarding unit. It substitutes the WB-stage value for the store data, performs the data-memory access, and holds the MEM/WB pipeline register.
- It is the receiving end of the memory-forwarding path: the forwarding unit decides, this block applies.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in data memory; must be a power of two.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exmem_mem_read  in  1  lw in MEM.
- exmem_mem_write  in  1  sw in MEM.
- exmem_mem_to_reg  in  1  WB selects memory data.
- exmem_reg_write  in  1  instruction writes the register file.
- exmem_alu_result  in  32  effective address, or ALU result.
- exmem_write_data  in  32  store data (rt value) from EX/MEM.
- exmem_write_reg  in  5  destination register.
- forward_m  in  1  1 = store data taken from memwb_result.
- memwb_stall  in  1  hold MEM/WB; suppress memory write.
- memwb_flush  in  1  squash MEM instruction.
- memwb_reg_write  out  1  registered control.
- memwb_mem_to_reg  out  1  registered control.
- memwb_write_reg  out  5  registered destination.
- memwb_read_data  out  32  registered load data.
- memwb_alu_result  out  32  registered ALU result.
- memwb_result  out  32  WB value: memwb_mem_to_reg ? memwb_read_data : memwb_alu_result (combinational).
- align_fault  out  1  sticky misaligned-access flag.

Behaviour:
- **Reset** (async, immediate): all memwb_* registers are 0, so memwb_result = 0. align_fault = 0. Memory contents are not cleared and are undefined until written.
- **Word index**: exmem_alu_result[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- **Alignment**: any access with exmem_alu_result[1:0] != 0 is misaligned. A misaligned access:
  - suppresses the write;
  - reads 0;
  - sets align_fault on the next edge.
  - align_fault stays set until reset.
- **Store data**: store_data = forward_m ? memwb_result : exmem_write_data. The select is combinational and is evaluated in the same cycle as the write.
- **Write**: synchronous at the rising clk edge when all of these hold: exmem_mem_write=1, aligned, memwb_stall=0, memwb_flush=0.
- **Read**: combinational from the array when exmem_mem_read=1 and aligned; otherwise read data = 0.
  - A load in the cycle after a store to the same word returns the new data.
- **MEM/WB register** per edge:
  - flush=1 (takes priority over stall): load a bubble, i.e. all controls 0, memwb_write_reg 0, data 0.
  - stall=1: hold all values.
  - Otherwise: capture exmem controls, exmem_write_reg, read data and exmem_alu_result.
- **Latency**: one cycle from EX/MEM inputs to memwb_* outputs.
- **exmem_mem_read and exmem_mem_write both 1**: illegal upstream. The write proceeds and the read returns the old data; no error is flagged.
- **Reset mid-write**: an asserted reset blocks the write at that edge.

Decomposition:
- Shared package: DATA_W, opcode constants OP_LW=6'b100011 and OP_SW=6'b101011, and a MEM/WB bundle typedef (reg_write, mem_to_reg, write_reg, read_data, alu_result).
- One sub-module, data_memory: single-port array with synchronous write, combinational read and the alignment check. The MEM/WB register and the forward mux stay in pipe_mem_stage.

Test Plan:
- Reset asserted mid-cycle → all memwb_* outputs and align_fault are 0 immediately, without waiting for a clock edge.
- sw 0xDEADBEEF to addr 0x10, then lw from 0x10 → memwb_read_data = 0xDEADBEEF and memwb_result = 0xDEADBEEF one cycle after the lw.
- lw $1 from 0x20 (holding 0x12345678), followed directly by sw $1 to 0x24 with forward_m=1 and exmem_write_data=0xBAD → word 0x24 holds 0x12345678; the same sequence with forward_m=0 stores 0xBAD.
- sw to 0x13 → no write (word 0x10 is unchanged), align_fault=1 after the edge and stays 1 through later aligned accesses until reset.
- sw to 0x10 with memwb_stall=1 → memory is unchanged and memwb_* hold their previous values; the same store with stall and flush both 1 → memory is unchanged and MEM/WB becomes a bubble (memwb_reg_write=0).
- With DEPTH_WORDS=256: sw 0x55 to address 0x400, then lw from 0x000 → returns 0x55 (wrap-around).
